// File: rtl/swipt_response_tx.sv
// Serial response transmitter for the SWIPT back-channel: frames {start, mode, type, data, checksum}
// MSB first at BIT_PERIOD clocks per bit, followed by a forced-low guard interval.
module swipt_response_tx #(
    parameter int BIT_PERIOD = 200000,
    parameter int GUARD_BITS = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       swiptAlive,
    input  logic [1:0] program_sel,
    input  logic       txReq,
    input  logic [1:0] txMode,
    input  logic [1:0] txType,
    input  logic [7:0] txData,
    output logic       dout,
    output logic       txBusy,
    output logic       txDone,
    output logic       txAbort
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [19:0] BIT_LOAD   = 20'(BIT_PERIOD - 1);
    localparam logic [3:0]  GUARD_LOAD = 4'(GUARD_BITS - 1);
    localparam logic [4:0]  LAST_IDX   = 5'd20;

    function automatic logic [7:0] ones_count(input logic [11:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < 12; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [20:0] frame_bits(input logic [1:0] m, input logic [1:0] t,
                                               input logic [7:0] d, input logic [7:0] ck);
        return {1'b1, m, t, d, ck};
    endfunction

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  gidx_q, gidx_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  typ_q, typ_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  cksum_q, cksum_d;
    logic        dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic        link_ok;
    logic        accept;
    logic [20:0] frame;
    logic [4:0]  idx_next;

    assign link_ok  = swiptAlive && (program_sel == 2'b11);
    assign accept   = txReq && link_ok;
    assign frame    = frame_bits(mode_q, typ_q, data_q, cksum_q);
    assign idx_next = idx_q - 5'd1;

    // Next-state and registered-output logic; a dropped link wins over counter expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        gidx_d  = gidx_q;
        mode_d  = mode_q;
        typ_d   = typ_q;
        data_d  = data_q;
        cksum_d = cksum_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                busy_d = 1'b0;
                if (accept) begin
                    state_d = SEND;
                    mode_d  = txMode;
                    typ_d   = txType;
                    data_d  = txData;
                    cksum_d = ones_count({txMode, txType, txData});
                    cnt_d   = BIT_LOAD;
                    idx_d   = LAST_IDX;
                    dout_d  = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND, GUARD: begin
                if (!link_ok) begin
                    state_d = IDLE;
                    cnt_d   = 20'd0;
                    idx_d   = 5'd0;
                    gidx_d  = 4'd0;
                    dout_d  = 1'b0;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                end else if (cnt_q != 20'd0) begin
                    cnt_d = cnt_q - 20'd1;
                end else if (state_q == SEND) begin
                    cnt_d = BIT_LOAD;
                    if (idx_q == 5'd0) begin
                        state_d = GUARD;
                        gidx_d  = GUARD_LOAD;
                        dout_d  = 1'b0;
                    end else begin
                        idx_d  = idx_next;
                        dout_d = frame[idx_next];
                    end
                end else begin
                    if (gidx_q == 4'd0) begin
                        state_d = DONE;
                        cnt_d   = 20'd0;
                        dout_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        gidx_d = gidx_q - 4'd1;
                        cnt_d  = BIT_LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                dout_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                dout_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= 20'd0;
            idx_q   <= 5'd0;
            gidx_q  <= 4'd0;
            mode_q  <= 2'd0;
            typ_q   <= 2'd0;
            data_q  <= 8'd0;
            cksum_q <= 8'd0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            gidx_q  <= gidx_d;
            mode_q  <= mode_d;
            typ_q   <= typ_d;
            data_q  <= data_d;
            cksum_q <= cksum_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign dout    = dout_q;
    assign txBusy  = busy_q;
    assign txDone  = done_q;
    assign txAbort = abort_q;

endmodule

// File: doc/swipt_response_tx.md
SWIPT_RESPONSE_TX -- requirements
Module: swipt_response_tx

Interface
REQ-001 The block SHALL have parameter BIT_PERIOD, default 200000, meaning clk cycles per transmitted bit (valid range 2..2^20-1).
REQ-002 The block SHALL have parameter GUARD_BITS, default 2, meaning bit periods of forced-low dout after the last frame bit (valid range 1..15).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 swiptAlive  input  1  link-up qualifier; 0 inhibits and aborts transmission.
REQ-006 program  input  2  operating program; transmission enabled only when 2'b11.
REQ-007 txReq  input  1  request to send one response frame; level-sampled.
REQ-008 txMode  input  2  mode field of response, captured on accept.
REQ-009 txType  input  2  type field of response, captured on accept.
REQ-010 txData  input  8  payload byte, captured on accept.
REQ-011 dout  output  1  serial response line to the load modulator.
REQ-012 txBusy  output  1  high from accept until end of guard or abort.
REQ-013 txDone  output  1  one-cycle pulse on completed frame.
REQ-014 txAbort  output  1  one-cycle pulse on aborted frame.

Function
REQ-015 The frame SHALL be 21 bits, MSB first: start bit 1, txMode[1:0], txType[1:0], txData[7:0], checksum[7:0].
REQ-016 The checksum SHALL be the number of 1 bits in {txMode,txType,txData}, zero-extended to 8 bits (range 0..12).
REQ-017 The FSM SHALL have states IDLE, SEND, GUARD, DONE.
REQ-018 IDLE: dout=0, txBusy=0; txReq=1 AND swiptAlive=1 AND program=2'b11 at edge E0 SHALL capture the fields and checksum, enter SEND, and drive dout=1 and txBusy=1 from E0.
REQ-019 SEND: frame bit k SHALL be driven on dout from edge E0+k*BIT_PERIOD for exactly BIT_PERIOD cycles, k=0..20.
REQ-020 At E0+21*BIT_PERIOD the FSM SHALL enter GUARD with dout=0 for GUARD_BITS*BIT_PERIOD cycles.
REQ-021 At guard end the FSM SHALL enter DONE for one cycle: txDone=1, txBusy=0, dout=0, then return to IDLE.
REQ-022 txReq SHALL be ignored in SEND, GUARD and DONE; no queuing; earliest next accept is the edge after DONE.
REQ-023 Captured fields SHALL be held stable; changes on txMode/txType/txData after accept SHALL NOT affect the frame.
REQ-024 In SEND or GUARD, swiptAlive=0 or program!=2'b11 at an edge SHALL cause, from that edge, state IDLE, dout=0, txBusy=0, txAbort=1 for one cycle, and no txDone.
REQ-025 An abort condition and the final bit/guard counter expiry on the same edge SHALL resolve as abort.
REQ-026 The bit counter SHALL be 20 bits, load BIT_PERIOD-1, and decrement to 0 without wrap; the bit index SHALL count 20 down to 0.
REQ-027 dout SHALL be driven directly from a register, glitch-free.

Reset
REQ-028 nrst=0 at an edge SHALL force, from that edge: state IDLE, dout=0, txBusy=0, txDone=0, txAbort=0, counters and captured fields 0.
REQ-029 Reset SHALL take priority over accept, abort and counter expiry, including mid-frame; no txDone or txAbort pulse SHALL result from reset.
REQ-030 The first accept after reset release SHALL be possible on the first edge with nrst=1.

Verification (BIT_PERIOD=4, GUARD_BITS=2)
REQ-031 txMode=00, txType=01, txData=8'hA5 accepted at E0 -> dout = 1,0,0,0,1,1,0,1,0,0,1,0,1,0,0,0,0,0,1,0,1 in 4-cycle bits from E0; dout=0 E84..E92; txDone=1 only in the cycle after E92; txBusy=1 E0..E92.
REQ-032 txData=8'hFF, txMode=11, txType=11 -> checksum bits 00001100; txData=00, mode 00, type 00 -> checksum 00000000 (frame = 1 followed by 20 zeros).
REQ-033 swiptAlive dropped at E0+30 -> dout=0, txBusy=0 from E0+30, txAbort pulse 1 cycle, txDone never asserts.
REQ-034 txReq held high continuously with program=11 -> back-to-back frames, second accept on the edge after DONE; txReq pulses during SEND ignored.
REQ-035 nrst=0 at E0+50 -> all outputs 0 that cycle, no pulses; txReq with program=2'b10 or swiptAlive=0 in IDLE -> no accept, dout stays 0.
